// File: rtl/cfg_command_engine.sv
// cfg_command_engine
//   Command engine between the FX2 EP4 command stream (in), the EP8 reply stream (out)
//   and the configuration RAM. Handles CONFIG_GET_REG (0x31), CONFIG_SET_REG (0x30) and
//   HWCON_SET (0x40); anything else gets an 0xF2 error reply.
//
//   Optional feature macro: CFG_CMD_TIMEOUT_EN enables a watchdog that aborts a stalled
//   EP4 read or EP8 reply after TIMEOUT_CYCLES cycles without progress.
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   in_cmd_valid/id/length, in_ready, in_data, in_read, in_cmd_ack : EP4 side
//   out_cmd_valid/id/length, out_ready, out_write, out_data         : EP8 side
//   cfg_addr, cfg_read, cfg_write, cfg_wdata, cfg_rdata             : config RAM
//   direction, num_channels : per-port mode bits selecting the register bank
//   hwcons  : per-port HWCON registers, port p in bits [8p+7:8p]
//   busy    : engine not idle
//   timeout : one-cycle pulse on watchdog abort
module cfg_command_engine #(
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned MAX_CMD_LEN    = 8,
  parameter int unsigned NUM_REGS       = 16,
  parameter logic [10:0] CFG_BASE       = 11'h400,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_cmd_valid,
  input  logic [7:0]             in_cmd_id,
  input  logic [15:0]            in_cmd_length,
  input  logic                   in_ready,
  input  logic [7:0]             in_data,
  output logic                   in_read,
  output logic                   in_cmd_ack,
  output logic                   out_cmd_valid,
  output logic [7:0]             out_cmd_id,
  output logic [15:0]            out_cmd_length,
  input  logic                   out_ready,
  output logic                   out_write,
  output logic [7:0]             out_data,
  output logic [10:0]            cfg_addr,
  output logic                   cfg_read,
  output logic                   cfg_write,
  output logic [7:0]             cfg_wdata,
  input  logic [7:0]             cfg_rdata,
  input  logic [NUM_PORTS-1:0]   direction,
  input  logic [NUM_PORTS-1:0]   num_channels,
  output logic [8*NUM_PORTS-1:0] hwcons,
  output logic                   busy,
  output logic                   timeout
);

  // Buffer always holds at least port/reg/value so decode never indexes out of range.
  localparam int unsigned BufLen = (MAX_CMD_LEN < 3) ? 3 : MAX_CMD_LEN;
  localparam int unsigned IdxW   = $clog2(BufLen);

  localparam logic [7:0] CmdSetReg   = 8'h30;
  localparam logic [7:0] CmdGetReg   = 8'h31;
  localparam logic [7:0] CmdHwconSet = 8'h40;
  localparam logic [7:0] RspGetReg   = 8'h32;
  localparam logic [7:0] ErrAddr     = 8'hF0;
  localparam logic [7:0] ErrReadOnly = 8'hF1;
  localparam logic [7:0] ErrCmd      = 8'hF2;
  localparam logic [3:0] LastSlot    = 4'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    StIdle, StRead, StDecode, StProbe, StCompare, StValue, StWrite, StReplyHdr, StReplyData
  } state_e;

  state_e                 r_state, w_state_next;
  logic [15:0]            r_count, w_count_next;
  logic [7:0]             r_buf [BufLen];
  logic                   w_buf_clr, w_buf_we;
  logic [7:0]             r_cmd_id, w_cmd_id_next;
  logic [10:0]            r_bank, w_bank_next;
  logic [3:0]             r_slot, w_slot_next;
  logic [10:0]            r_cfg_addr, w_cfg_addr_next;
  logic                   r_cfg_read, w_cfg_read_next;
  logic                   r_cfg_write, w_cfg_write_next;
  logic [7:0]             r_cfg_wdata, w_cfg_wdata_next;
  logic                   r_in_cmd_ack, w_in_cmd_ack_next;
  logic                   r_out_cmd_valid, w_out_cmd_valid_next;
  logic [7:0]             r_out_cmd_id, w_out_cmd_id_next;
  logic [15:0]            r_out_cmd_length, w_out_cmd_length_next;
  logic [7:0]             r_out_data, w_out_data_next;
  logic [1:0]             r_out_idx, w_out_idx_next;
  logic [7:0]             r_rep0, r_rep1, r_rep2;
  logic [7:0]             w_rep0_next, w_rep1_next, w_rep2_next;
  logic                   r_val_pend, w_val_pend_next;
  logic [8*NUM_PORTS-1:0] r_hwcons, w_hwcons_next;
  logic                   r_busy;

  // Reply request raised inside the state case, applied once after it.
  logic                   w_rep_start;
  logic [7:0]             w_rep_id;
  logic [15:0]            w_rep_len;
  logic [7:0]             w_rep_b0, w_rep_b1;

  logic [7:0]             w_port, w_reg, w_val;
  logic [1:0]             w_port_idx;
  logic                   w_port_ok;
  logic [3:0]             w_dir4, w_nch4;
  logic [10:0]            w_bank;
  logic                   w_hit;
  logic [1:0]             w_idx_inc;
  logic [3:0]             w_slot_inc;

  assign w_port     = r_buf[0];
  assign w_reg      = r_buf[1];
  assign w_val      = r_buf[2];
  assign w_port_idx = w_port[1:0];
  assign w_port_ok  = ({24'd0, w_port} < NUM_PORTS);
  assign w_dir4     = 4'(direction);
  assign w_nch4     = 4'(num_channels);
  // Fields do not overlap, so concatenation equals the sum of the shifted terms.
  assign w_bank     = CFG_BASE + {2'b00, w_port_idx, w_dir4[w_port_idx], w_nch4[w_port_idx],
                                  5'b00000};
  assign w_hit      = cfg_rdata[7] && (cfg_rdata[5:0] == w_reg[5:0]);
  assign w_idx_inc  = r_out_idx + 2'd1;
  assign w_slot_inc = r_slot + 4'd1;

  assign in_read   = (r_state == StRead) && in_ready && (r_count != in_cmd_length);
  assign out_write = (r_state == StReplyData) && out_ready;

`ifdef CFG_CMD_TIMEOUT_EN
  logic [15:0] r_wdog, w_wdog_next;
  logic        r_timeout, w_timeout_next;
  logic        w_progress;
  assign w_progress = in_read || out_write ||
                      ((r_state == StRead) && (r_count == in_cmd_length)) ||
                      ((r_state == StReplyHdr) && out_ready);
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    w_state_next          = r_state;
    w_count_next          = r_count;
    w_buf_clr             = 1'b0;
    w_buf_we              = 1'b0;
    w_cmd_id_next         = r_cmd_id;
    w_bank_next           = r_bank;
    w_slot_next           = r_slot;
    w_cfg_addr_next       = r_cfg_addr;
    w_cfg_read_next       = 1'b0;
    w_cfg_write_next      = 1'b0;
    w_cfg_wdata_next      = r_cfg_wdata;
    w_in_cmd_ack_next     = 1'b0;
    w_out_cmd_valid_next  = r_out_cmd_valid;
    w_out_cmd_id_next     = r_out_cmd_id;
    w_out_cmd_length_next = r_out_cmd_length;
    w_out_data_next       = r_out_data;
    w_out_idx_next        = r_out_idx;
    w_rep0_next           = r_rep0;
    w_rep1_next           = r_rep1;
    w_rep2_next           = r_rep2;
    w_val_pend_next       = r_val_pend;
    w_hwcons_next         = r_hwcons;
    w_rep_start           = 1'b0;
    w_rep_id              = 8'h00;
    w_rep_len             = 16'd0;
    w_rep_b0              = w_port;
    w_rep_b1              = w_reg;
`ifdef CFG_CMD_TIMEOUT_EN
    w_wdog_next           = 16'd0;
    w_timeout_next        = 1'b0;
`endif

    case (r_state)
      StIdle: begin
        // A header being retired this cycle (ack still visible) must not restart a read.
        if (in_cmd_valid && !r_in_cmd_ack) begin
          w_state_next = StRead;
          w_count_next = 16'd0;
          w_buf_clr    = 1'b1;
        end
      end
      StRead: begin
        if (r_count == in_cmd_length) begin
          w_in_cmd_ack_next = 1'b1;
          w_cmd_id_next     = in_cmd_id;
          w_state_next      = StDecode;
        end else if (in_ready) begin
          w_buf_we     = ({16'd0, r_count} < MAX_CMD_LEN);
          w_count_next = r_count + 16'd1;
        end
      end
      StDecode: begin
        w_bank_next = w_bank;
        w_slot_next = 4'd0;
        if (r_cmd_id == CmdGetReg || r_cmd_id == CmdSetReg) begin
          if (!w_port_ok) begin
            w_rep_start = 1'b1;
            w_rep_id    = ErrAddr;
            w_rep_len   = 16'd2;
          end else begin
            w_cfg_read_next = 1'b1;
            w_cfg_addr_next = w_bank;
            w_state_next    = StProbe;
          end
        end else if (r_cmd_id == CmdHwconSet) begin
          if (!w_port_ok) begin
            w_rep_start = 1'b1;
            w_rep_id    = ErrAddr;
            w_rep_len   = 16'd2;
          end else begin
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
              if (w_port_idx == 2'(p)) w_hwcons_next[8*p +: 8] = w_reg;
            end
            w_state_next = StIdle;
          end
        end else begin
          w_rep_start = 1'b1;
          w_rep_id    = ErrCmd;
          w_rep_len   = 16'd1;
          w_rep_b0    = r_cmd_id;
        end
      end
      StProbe: w_state_next = StCompare;
      StCompare: begin
        if (w_hit) begin
          if (r_cmd_id == CmdGetReg) begin
            w_cfg_read_next = 1'b1;
            w_cfg_addr_next = r_cfg_addr + 11'd1;
            w_state_next    = StValue;
          end else if (cfg_rdata[6]) begin
            w_cfg_write_next = 1'b1;
            w_cfg_addr_next  = r_cfg_addr + 11'd1;
            w_cfg_wdata_next = w_val;
            w_state_next     = StWrite;
          end else begin
            w_rep_start = 1'b1;
            w_rep_id    = ErrReadOnly;
            w_rep_len   = 16'd2;
          end
        end else if (r_slot == LastSlot) begin
          w_rep_start = 1'b1;
          w_rep_id    = ErrAddr;
          w_rep_len   = 16'd2;
        end else begin
          w_slot_next     = w_slot_inc;
          w_cfg_read_next = 1'b1;
          w_cfg_addr_next = r_bank + {6'd0, w_slot_inc, 1'b0};
          w_state_next    = StProbe;
        end
      end
      StValue: begin
        // Value byte lands on cfg_rdata during the first header cycle.
        w_rep_start     = 1'b1;
        w_rep_id        = RspGetReg;
        w_rep_len       = 16'd3;
        w_val_pend_next = 1'b1;
      end
      StWrite: w_state_next = StIdle;
      StReplyHdr: begin
        if (r_val_pend) begin
          w_rep2_next     = cfg_rdata;
          w_val_pend_next = 1'b0;
        end
        if (out_ready) begin
          w_out_cmd_valid_next = 1'b0;
          if (r_out_cmd_length == 16'd0) begin
            w_state_next = StIdle;
          end else begin
            w_out_idx_next  = 2'd0;
            w_out_data_next = r_rep0;
            w_state_next    = StReplyData;
          end
        end
      end
      StReplyData: begin
        if (out_ready) begin
          if (r_out_cmd_length == {14'd0, r_out_idx} + 16'd1) begin
            w_state_next = StIdle;
          end else begin
            w_out_idx_next = w_idx_inc;
            case (w_idx_inc)
              2'd1:    w_out_data_next = r_rep1;
              default: w_out_data_next = r_rep2;
            endcase
          end
        end
      end
      default: w_state_next = StIdle;
    endcase

    if (w_rep_start) begin
      w_out_cmd_valid_next  = 1'b1;
      w_out_cmd_id_next     = w_rep_id;
      w_out_cmd_length_next = w_rep_len;
      w_rep0_next           = w_rep_b0;
      w_rep1_next           = w_rep_b1;
      w_rep2_next           = 8'h00;
      w_state_next          = StReplyHdr;
    end

`ifdef CFG_CMD_TIMEOUT_EN
    if (r_state == StRead || r_state == StReplyHdr || r_state == StReplyData) begin
      if (w_progress) begin
        w_wdog_next = 16'd0;
      end else if (r_wdog == 16'(TIMEOUT_CYCLES)) begin
        w_timeout_next       = 1'b1;
        w_state_next         = StIdle;
        w_out_cmd_valid_next = 1'b0;
        w_val_pend_next      = 1'b0;
        w_in_cmd_ack_next    = (r_state == StRead);
      end else begin
        w_wdog_next = r_wdog + 16'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= StIdle;
      r_count          <= 16'd0;
      r_cmd_id         <= 8'h00;
      r_bank           <= 11'd0;
      r_slot           <= 4'd0;
      r_cfg_addr       <= 11'd0;
      r_cfg_read       <= 1'b0;
      r_cfg_write      <= 1'b0;
      r_cfg_wdata      <= 8'h00;
      r_in_cmd_ack     <= 1'b0;
      r_out_cmd_valid  <= 1'b0;
      r_out_cmd_id     <= 8'h00;
      r_out_cmd_length <= 16'd0;
      r_out_data       <= 8'h00;
      r_out_idx        <= 2'd0;
      r_rep0           <= 8'h00;
      r_rep1           <= 8'h00;
      r_rep2           <= 8'h00;
      r_val_pend       <= 1'b0;
      r_hwcons         <= '0;
      r_busy           <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_count          <= w_count_next;
      r_cmd_id         <= w_cmd_id_next;
      r_bank           <= w_bank_next;
      r_slot           <= w_slot_next;
      r_cfg_addr       <= w_cfg_addr_next;
      r_cfg_read       <= w_cfg_read_next;
      r_cfg_write      <= w_cfg_write_next;
      r_cfg_wdata      <= w_cfg_wdata_next;
      r_in_cmd_ack     <= w_in_cmd_ack_next;
      r_out_cmd_valid  <= w_out_cmd_valid_next;
      r_out_cmd_id     <= w_out_cmd_id_next;
      r_out_cmd_length <= w_out_cmd_length_next;
      r_out_data       <= w_out_data_next;
      r_out_idx        <= w_out_idx_next;
      r_rep0           <= w_rep0_next;
      r_rep1           <= w_rep1_next;
      r_rep2           <= w_rep2_next;
      r_val_pend       <= w_val_pend_next;
      r_hwcons         <= w_hwcons_next;
      r_busy           <= (w_state_next != StIdle);
    end
  end

`ifdef CFG_CMD_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdog    <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      r_wdog    <= w_wdog_next;
      r_timeout <= w_timeout_next;
    end
  end
`endif

  // Payload buffer; bytes past MAX_CMD_LEN are popped but never stored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(BufLen); i++) r_buf[i] <= 8'h00;
    end else if (w_buf_clr) begin
      for (int i = 0; i < int'(BufLen); i++) r_buf[i] <= 8'h00;
    end else if (w_buf_we) begin
      r_buf[r_count[IdxW-1:0]] <= in_data;
    end
  end

  // Buffer bytes beyond the value byte and upper count bits have no consumer.
  logic w_unused;
  always_comb begin
    w_unused = ^r_count;
    for (int i = 3; i < int'(BufLen); i++) w_unused = w_unused ^ (^r_buf[i]);
  end

  assign in_cmd_ack     = r_in_cmd_ack;
  assign out_cmd_valid  = r_out_cmd_valid;
  assign out_cmd_id     = r_out_cmd_id;
  assign out_cmd_length = r_out_cmd_length;
  assign out_data       = r_out_data;
  assign cfg_addr       = r_cfg_addr;
  assign cfg_read       = r_cfg_read;
  assign cfg_write      = r_cfg_write;
  assign cfg_wdata      = r_cfg_wdata;
  assign hwcons         = r_hwcons;
  assign busy           = r_busy;

endmodule

// File: tb/tb_cfg_command_engine.sv
// Directed bench for cfg_command_engine: drives EP4 commands, models the config RAM
// (one-cycle read latency) and records EP8 replies and RAM strobes.
module tb_cfg_command_engine;

  logic        clk, reset;
  logic        in_cmd_valid;
  logic [7:0]  in_cmd_id;
  logic [15:0] in_cmd_length;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_read, in_cmd_ack;
  logic        out_cmd_valid;
  logic [7:0]  out_cmd_id;
  logic [15:0] out_cmd_length;
  logic        out_ready, out_write;
  logic [7:0]  out_data;
  logic [10:0] cfg_addr;
  logic        cfg_read, cfg_write;
  logic [7:0]  cfg_wdata, cfg_rdata;
  logic [3:0]  direction, num_channels;
  logic [31:0] hwcons;
  logic        busy, timeout;

  cfg_command_engine #(
    .NUM_PORTS      (4),
    .MAX_CMD_LEN    (8),
    .NUM_REGS       (16),
    .CFG_BASE       (11'h400),
    .TIMEOUT_CYCLES (100)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .in_cmd_valid   (in_cmd_valid),
    .in_cmd_id      (in_cmd_id),
    .in_cmd_length  (in_cmd_length),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_read        (in_read),
    .in_cmd_ack     (in_cmd_ack),
    .out_cmd_valid  (out_cmd_valid),
    .out_cmd_id     (out_cmd_id),
    .out_cmd_length (out_cmd_length),
    .out_ready      (out_ready),
    .out_write      (out_write),
    .out_data       (out_data),
    .cfg_addr       (cfg_addr),
    .cfg_read       (cfg_read),
    .cfg_write      (cfg_write),
    .cfg_wdata      (cfg_wdata),
    .cfg_rdata      (cfg_rdata),
    .direction      (direction),
    .num_channels   (num_channels),
    .hwcons         (hwcons),
    .busy           (busy),
    .timeout        (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Config RAM model: written only by the stimulus process.
  logic [7:0] mem [0:2047];
  initial cfg_rdata = 8'h00;
  always @(posedge clk) if (cfg_read) cfg_rdata <= mem[cfg_addr];

  // Event monitor, sampled mid-cycle.
  int c_rd = 0, c_wr = 0, c_inrd = 0, c_ack = 0, c_to = 0, c_hdr = 0, c_byte = 0;
  logic [10:0] l_wr_addr = '0;
  logic [7:0]  l_wr_data = '0, l_hdr_id = '0;
  logic [15:0] l_hdr_len = '0;
  logic [7:0]  rep_bytes [0:255];
  always @(negedge clk) begin
    if (cfg_read) c_rd++;
    if (cfg_write) begin c_wr++; l_wr_addr = cfg_addr; l_wr_data = cfg_wdata; end
    if (in_read) c_inrd++;
    if (in_cmd_ack) c_ack++;
    if (timeout) c_to++;
    if (out_cmd_valid && out_ready) begin c_hdr++; l_hdr_id = out_cmd_id; l_hdr_len = out_cmd_length; end
    if (out_write) begin rep_bytes[c_byte % 256] = out_data; c_byte++; end
  end

  int b_rd, b_wr, b_inrd, b_ack, b_to, b_hdr, b_byte;
  int n_checks = 0, n_fail = 0;
  logic [7:0] pl [0:15];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_rd = c_rd; b_wr = c_wr; b_inrd = c_inrd; b_ack = c_ack;
    b_to = c_to; b_hdr = c_hdr; b_byte = c_byte;
  endtask

  // Presents a header and feeds payload from pl[]; stops feeding after stall_at bytes.
  task automatic send_cmd(input logic [7:0] id, input int len, input int stall_at,
                          input int max_cyc, output bit got_ack);
    int idx = 0;
    got_ack = 1'b0;
    @(posedge clk); #1;
    in_cmd_valid = 1'b1; in_cmd_id = id; in_cmd_length = 16'(len);
    for (int cyc = 0; cyc < max_cyc && !got_ack; cyc++) begin
      in_ready = (idx < len) && (idx < stall_at);
      in_data  = (idx < 16) ? pl[idx] : 8'h00;
      @(negedge clk);
      if (in_read) idx++;
      if (in_cmd_ack) got_ack = 1'b1;
      @(posedge clk); #1;
    end
    in_cmd_valid = 1'b0; in_ready = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    check_eq({tag, "_idle"}, 32'(ok), 1);
  endtask

  task automatic check_reply(input string tag, input logic [7:0] id, input int len,
                             input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    logic [7:0] e [3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    check_eq({tag, "_hdr_n"}, 32'(c_hdr - b_hdr), 1);
    check_eq({tag, "_id"}, 32'(l_hdr_id), 32'(id));
    check_eq({tag, "_len"}, 32'(l_hdr_len), 32'(len));
    check_eq({tag, "_bytes"}, 32'(c_byte - b_byte), 32'(len));
    for (int i = 0; i < len && i < 3; i++)
      check_eq($sformatf("%s_b%0d", tag, i), 32'(rep_bytes[(b_byte + i) % 256]), 32'(e[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bit ack;
    bit held;
    reset = 1'b1; in_cmd_valid = 1'b0; in_cmd_id = '0; in_cmd_length = '0;
    in_ready = 1'b0; in_data = '0; out_ready = 1'b1;
    direction = 4'b0000; num_channels = 4'b0010;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) pl[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_out_valid", 32'(out_cmd_valid), 0);
    check_eq("rst_hwcons", hwcons, 0);
    check_eq("rst_cfg_addr", 32'(cfg_addr), 0);
    check_eq("rst_strobes", {29'd0, cfg_read, cfg_write, in_cmd_ack}, 0);

    // GET port 1 reg 5; bank 0x4A0 (dir 0, nch 1), hit in slot 2
    mem[11'h4A0] = 8'h05;  // unused slot with matching reg field
    mem[11'h4A2] = 8'hC6;
    mem[11'h4A4] = 8'h85;
    mem[11'h4A5] = 8'h3C;
    pl[0] = 8'h01; pl[1] = 8'h05;
    snap();
    send_cmd(8'h31, 2, 99, 50, ack);
    check_eq("get_ack", 32'(ack), 1);
    wait_idle("get");
    check_reply("get", 8'h32, 3, 8'h01, 8'h05, 8'h3C);
    check_eq("get_reads", 32'(c_rd - b_rd), 4);
    check_eq("get_writes", 32'(c_wr - b_wr), 0);

    // SET port 0 reg 2 value 0x77, writable slot 0
    mem[11'h400] = 8'hC2;
    pl[0] = 8'h00; pl[1] = 8'h02; pl[2] = 8'h77;
    snap();
    send_cmd(8'h30, 3, 99, 50, ack);
    wait_idle("set_w");
    check_eq("set_w_writes", 32'(c_wr - b_wr), 1);
    check_eq("set_w_addr", 32'(l_wr_addr), 32'h401);
    check_eq("set_w_data", 32'(l_wr_data), 32'h77);
    check_eq("set_w_replies", 32'(c_hdr - b_hdr), 0);

    // Same SET against a read-only slot
    mem[11'h400] = 8'h82;
    snap();
    send_cmd(8'h30, 3, 99, 50, ack);
    wait_idle("set_ro");
    check_eq("set_ro_writes", 32'(c_wr - b_wr), 0);
    check_reply("set_ro", 8'hF1, 2, 8'h00, 8'h02, 8'h00);

    // GET on empty bank (port 2 -> 0x500): full sweep
    pl[0] = 8'h02; pl[1] = 8'h09;
    snap();
    send_cmd(8'h31, 2, 99, 50, ack);
    wait_idle("empty");
    check_eq("empty_probes", 32'(c_rd - b_rd), 16);
    check_reply("empty", 8'hF0, 2, 8'h02, 8'h09, 8'h00);

    // HWCON_SET port 0 then port 3
    pl[0] = 8'h00; pl[1] = 8'h11;
    send_cmd(8'h40, 2, 99, 50, ack);
    wait_idle("hw0");
    pl[0] = 8'h03; pl[1] = 8'hA5;
    snap();
    send_cmd(8'h40, 2, 99, 50, ack);
    wait_idle("hw3");
    check_eq("hw3_hwcons", hwcons, 32'hA500_0011);
    check_eq("hw3_replies", 32'(c_hdr - b_hdr), 0);

    // HWCON_SET with out-of-range port
    pl[0] = 8'h04; pl[1] = 8'h5A;
    snap();
    send_cmd(8'h40, 2, 99, 50, ack);
    wait_idle("hw4");
    check_reply("hw4", 8'hF0, 2, 8'h04, 8'h5A, 8'h00);
    check_eq("hw4_hwcons", hwcons, 32'hA500_0011);

    // Unknown command, 12 bytes (4 past the buffer), reply held while out_ready low
    for (int i = 0; i < 12; i++) pl[i] = 8'(8'hB0 + i);
    out_ready = 1'b0;
    snap();
    send_cmd(8'h99, 12, 99, 60, ack);
    check_eq("unk_reads", 32'(c_inrd - b_inrd), 12);
    check_eq("unk_acks", 32'(c_ack - b_ack), 1);
    held = 1'b0;
    for (int i = 0; i < 20 && !held; i++) begin
      @(negedge clk);
      held = out_cmd_valid;
    end
    repeat (5) begin
      @(negedge clk);
      held = held & out_cmd_valid;
    end
    check_eq("unk_held", 32'(held), 1);
    check_eq("unk_no_xfer", 32'(c_hdr - b_hdr), 0);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle("unk");
    check_reply("unk", 8'hF2, 1, 8'h99, 8'h00, 8'h00);

    // Zero-length command
    snap();
    send_cmd(8'h55, 0, 99, 20, ack);
    wait_idle("zero");
    check_eq("zero_reads", 32'(c_inrd - b_inrd), 0);
    check_eq("zero_ack", 32'(c_ack - b_ack), 1);
    check_reply("zero", 8'hF2, 1, 8'h55, 8'h00, 8'h00);

`ifdef CFG_CMD_TIMEOUT_EN
    // Stall after 1 of 3 bytes; watchdog aborts and acks
    pl[0] = 8'h01; pl[1] = 8'h05; pl[2] = 8'h00;
    snap();
    send_cmd(8'h31, 3, 1, 300, ack);
    check_eq("wd_ack", 32'(ack), 1);
    wait_idle("wd");
    check_eq("wd_pulse", 32'(c_to - b_to), 1);
    check_eq("wd_reads", 32'(c_inrd - b_inrd), 1);
    check_eq("wd_replies", 32'(c_hdr - b_hdr), 0);
`else
    check_eq("no_timeout_pulses", 32'(c_to), 0);
`endif

    // Reset in the middle of a stalled EP4 read
    pl[0] = 8'h01; pl[1] = 8'h05; pl[2] = 8'h00;
    snap();
    send_cmd(8'h31, 3, 1, 8, ack);
    check_eq("mid_no_ack", 32'(ack), 0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check_eq("mid_busy", 32'(busy), 0);
    check_eq("mid_hwcons", hwcons, 0);
    check_eq("mid_strobes", {28'd0, cfg_read, cfg_write, in_read, out_cmd_valid}, 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("mid_acks", 32'(c_ack - b_ack), 0);
    check_eq("mid_reads", 32'(c_inrd - b_inrd), 1);
    check_eq("mid_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cfg_command_engine.md
# cfg_command_engine

Single-clock, parametrised command engine between the FX2 EP4 (command in) and EP8 (command out) streams and the configuration RAM. Supersedes the fixed 4-port controller with these additions:
- Generalised port count, payload buffer depth and register-slot count.
- CONFIG_GET_REG, CONFIG_SET_REG and HWCON_SET commands, each with a real EP8 reply or error reply.
- Optional watchdog.

## Interface
Parameters:
- NUM_PORTS, 4: DAC/ADC ports; 1..4.
- MAX_CMD_LEN, 8: payload bytes buffered; excess bytes are consumed and discarded.
- NUM_REGS, 16: slots searched per (port, direction, num_channels) bank; 1..16.
- CFG_BASE, 11'h400: bank base address.
- TIMEOUT_CYCLES, 65535: watchdog limit.

Ports (clock and reset first):
- clk  in  1  system clock; all logic samples on its rising edge.
- reset  in  1  asynchronous, active-high.
- in_cmd_valid  in  1  EP4 header pending. in_cmd_id and in_cmd_length are stable while this is high.
- in_cmd_id  in  8  command ID.
- in_cmd_length  in  16  payload bytes.
- in_ready  in  1  EP4 byte available on in_data.
- in_data  in  8  payload byte.
- in_read  out  1  pops in_data; only asserted while in_ready is high.
- in_cmd_ack  out  1  one-cycle pulse that retires the header.
- out_cmd_valid  out  1  reply header presented.
- out_cmd_id  out  8  reply ID.
- out_cmd_length  out  16  reply bytes.
- out_ready  in  1  EP8 accepts header or byte.
- out_write  out  1  reply byte valid.
- out_data  out  8  reply byte.
- cfg_addr  out  11  RAM address.
- cfg_read  out  1  read strobe.
- cfg_write  out  1  write strobe.
- cfg_wdata  out  8  write data.
- cfg_rdata  in  8  read data; valid the cycle after cfg_read.
- direction  in  NUM_PORTS  per-port direction.
- num_channels  in  NUM_PORTS  per-port channel-mode bit.
- hwcons  out  8*NUM_PORTS  per-port HWCON registers; port p occupies bits [8p+7:8p].
- busy  out  1  high in every state except IDLE.
- timeout  out  1  one-cycle pulse on watchdog abort.

## Operation
- All outputs reset to 0. State resets to IDLE. The payload buffer resets to 0.
- IDLE → READ when in_cmd_valid is high. On entry, clear the byte counter and the buffer.
- READ: each cycle with in_ready high, assert in_read and store in_data at buffer[count] if count < MAX_CMD_LEN; count increments on every byte. When count == in_cmd_length (zero-length commands included), pulse in_cmd_ack, latch the ID, then go to DECODE.
- DECODE:
  - Payload byte 0 is the port. A port ≥ NUM_PORTS gives error 8'hF0.
  - 8'h31 GET_REG (payload: port, reg) → SEARCH.
  - 8'h30 SET_REG (payload: port, reg, value) → SEARCH.
  - 8'h40 HWCON_SET (payload: port, value) → hwcons[port] ← value. No reply; go to IDLE.
  - Any other ID → reply 8'hF2, length 1, data = ID.
- SEARCH, slot i from 0:
  - Read flags at CFG_BASE + (port<<7) + (direction[port]<<6) + (num_channels[port]<<5) + (i<<1). Flags: bit7 used, bit6 writable, [5:0] register address.
  - Match is used && flags[5:0] == reg[5:0].
  - GET match: read address+1, then reply 8'h32, length 3: port, reg, value.
  - SET match, writable: one cycle with cfg_write=1, cfg_addr = address+1, cfg_wdata = value. No reply.
  - SET match, not writable: reply 8'hF1, length 2: port, reg.
  - No match after NUM_REGS slots: reply 8'hF0, length 2: port, reg.
- REPLY: hold out_cmd_valid until the cycle with out_ready high. Then present bytes in order, with out_write high and out_data valid; each byte transfers on a cycle where out_ready is high. After the last transfer, go to IDLE. A zero-length reply ends at the header transfer.
- A new in_cmd_valid is ignored unless the state is IDLE.

## Timing
- Memory probe: one slot every 2 cycles (issue, compare). A GET hit at slot i reaches REPLY 2i+4 cycles after DECODE.
- in_read/out_write are combinational with in_ready/out_ready, gated by state. All other outputs are registered.
- Reset mid-command:
  - All strobes drop immediately.
  - hwcons return to 0.
  - The partially read EP4 command is not acknowledged.

## Configuration
- CFG_CMD_TIMEOUT_EN defined:
  - A 16-bit counter runs in READ and REPLY and clears on every byte or header transfer.
  - When it reaches TIMEOUT_CYCLES: pulse timeout and go to IDLE. In READ, also pulse in_cmd_ack.
- Not defined: waits indefinitely; timeout is tied to 0.

## Test plan
- GET_REG, port 1, reg 5. Slot 2 holds 8'h85/8'h3C at dir=0, nch=1 (0x4A4/0x4A5) → reply 8'h32, length 3: 01 05 3C.
- SET_REG, port 0, reg 2, value 8'h77. Slot 0 flags 8'hC2 → a single write at 0x401 with 8'h77, no reply. Repeat with flags 8'h82 → reply 8'hF1: 00 02.
- GET_REG on an empty bank → exactly 16 probes, then reply 8'hF0: port, reg.
- HWCON_SET, port 3, value 8'hA5 → hwcons[31:24] = 8'hA5 and the other bytes unchanged. Same command with port 4 and NUM_PORTS=4 → reply 8'hF0.
- Command 8'h99 with 12 payload bytes and MAX_CMD_LEN=8 → 12 in_read pulses and one in_cmd_ack, then reply 8'hF2: 99. out_ready low for 5 cycles → reply held.
- CFG_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=100, in_ready stuck low after 1 of 3 bytes → timeout pulse after 100 cycles, then IDLE.
